// File: rtl/wb_pipelined_ram_slave.sv
// wb_pipelined_ram_slave: Wishbone pipelined-mode RAM slave.
// Requests are queued in order and serviced by a wait-state access engine.
module wb_pipelined_ram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_AW      = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int QDEPTH_LOG2 = 2,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  stall_o
);

  localparam int QD = 2 ** QDEPTH_LOG2;
  localparam int MD = 2 ** MEM_AW;
  localparam logic [QDEPTH_LOG2:0] FULL = QD[QDEPTH_LOG2:0];
  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [QDEPTH_LOG2:0] CNT_ZERO = '0;
  localparam logic [3:0] WS = WAIT_STATES[3:0];
  localparam logic [3:0] WS_LOAD = WS - 4'd1;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  // request queue storage
  logic                  q_we  [QD];
  logic [MEM_AW-1:0]     q_adr [QD];
  logic [DATA_WIDTH-1:0] q_dat [QD];

  logic [QDEPTH_LOG2-1:0] wr_ptr;
  logic [QDEPTH_LOG2-1:0] rd_ptr;
  logic [QDEPTH_LOG2:0]   count;

  logic [DATA_WIDTH-1:0] mem [MD];

  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic push;
  logic pop;
  logic enter_ack;
  logic from_head;

  logic                  work_we;
  logic [MEM_AW-1:0]     work_adr;
  logic [DATA_WIDTH-1:0] work_dat;

  logic                  acc_we;
  logic [MEM_AW-1:0]     acc_adr;
  logic [DATA_WIDTH-1:0] acc_dat;

  logic unused_adr_hi;
  assign unused_adr_hi = ^adr_i[ADDR_WIDTH-1:MEM_AW];

  // accept a request whenever the bus strobes and the queue has room
  always_comb begin
    push = cyc_i & stb_i & ~stall_o;
  end

  // engine state and wait counter register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next-state logic: pop, wait countdown, ACK entry; cyc_i low aborts
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    enter_ack = 1'b0;
    from_head = 1'b0;
    if (!cyc_i) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_ACK: begin
          if (count != CNT_ZERO) begin
            pop = 1'b1;
            if (NO_WAIT) begin
              state_nxt = S_ACK;
              enter_ack = 1'b1;
              from_head = 1'b1;
            end else begin
              state_nxt = S_WAIT;
              cnt_nxt   = WS_LOAD;
            end
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state_nxt = S_ACK;
            enter_ack = 1'b1;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // bus-facing outputs: gated ack and queue-full stall
  always_comb begin
    ack_o   = (state == S_ACK) & cyc_i;
    stall_o = (count == FULL);
  end

  // the access entering ACK comes from the queue head when there are no wait states
  always_comb begin
    acc_we  = work_we;
    acc_adr = work_adr;
    acc_dat = work_dat;
    if (from_head) begin
      acc_we  = q_we[rd_ptr];
      acc_adr = q_adr[rd_ptr];
      acc_dat = q_dat[rd_ptr];
    end
  end

  // queue pointers and occupancy; a dropped cycle flushes everything
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!cyc_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count
             + {{QDEPTH_LOG2{1'b0}}, push}
             - {{QDEPTH_LOG2{1'b0}}, pop};
    end
  end

  // queue entry storage, written at the tail on accept
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      q_we[wr_ptr]  <= we_i;
      q_adr[wr_ptr] <= adr_i[MEM_AW-1:0];
      q_dat[wr_ptr] <= dat_i;
    end
  end

  // work register holds the access while it serves its wait states
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      work_we  <= 1'b0;
      work_adr <= '0;
      work_dat <= '0;
    end else if (pop) begin
      work_we  <= q_we[rd_ptr];
      work_adr <= q_adr[rd_ptr];
      work_dat <= q_dat[rd_ptr];
    end
  end

  // read data is captured on the edge the access enters ACK
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dat_o <= '0;
    end else if (enter_ack) begin
      dat_o <= acc_we ? '0 : mem[acc_adr];
    end
  end

  // writes commit only on ACK entry, so aborted accesses never land
  always_ff @(posedge clk_i) begin
    if (enter_ack && acc_we && !reset_i) begin
      mem[acc_adr] <= acc_dat;
    end
  end

endmodule
